// File: rtl/video_scrambler_pkg.sv
// Shared constants and types for the BT.656 video scrambler/descrambler blocks.
// The key-line extractor and the sequence generator switch both import this.
package video_scrambler_pkg;

    localparam int         ACTIVE_VIDEO_WORDS = 1440;
    localparam logic [9:0] BT656_BLACK_Y      = 10'h040;
    localparam logic [9:0] BT656_BLACK_C      = 10'h200;

    typedef enum logic [2:0] {
        EXT_IDLE    = 3'd0,
        EXT_VBLANK  = 3'd1,
        EXT_ARMED   = 3'd2,
        EXT_CAPTURE = 3'd3,
        EXT_TAIL    = 3'd4,
        EXT_DONE    = 3'd5
    } extractor_state_e;

    // Even active-word indices carry Cb/Cr, odd indices carry Y.
    function automatic logic [9:0] black_word(input logic odd_idx);
        logic [9:0] word_v;
        if (odd_idx) begin
            word_v = BT656_BLACK_Y;
        end else begin
            word_v = BT656_BLACK_C;
        end
        return word_v;
    endfunction

endpackage

// File: rtl/sequence_extractor_if.sv
// Stream-side signal bundle of the key-line extractor.
// The master side feeds the stream; the slave side is the extractor.
interface sequence_extractor_if #(
    parameter int SEED_WORDS = 8
) ();

    logic                    H;
    logic                    V;
    logic [9:0]              bt656_stream_in;
    logic [9:0]              bt656_stream_out;
    logic                    V_out;
    logic [10*SEED_WORDS-1:0] seed_data;
    logic                    seed_load;
    logic                    seed_err;

    modport master (
        output H, V, bt656_stream_in,
        input  bt656_stream_out, V_out, seed_data, seed_load, seed_err
    );

    modport slave (
        input  H, V, bt656_stream_in,
        output bt656_stream_out, V_out, seed_data, seed_load, seed_err
    );

endinterface

// File: rtl/bt656_edge_detect.sv
// Registers the decoded H/V flags and reports their rising and falling edges.
// Shared between the key-line extractor and the key-line inserter.
module bt656_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic H,
    input  logic V,
    output logic h_rise,
    output logic h_fall,
    output logic v_rise,
    output logic v_fall
);

    logic prev_h_r;
    logic prev_v_r;

    // Previous-word H and V flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_h_r <= 1'b0;
            prev_v_r <= 1'b0;
        end else begin
            prev_h_r <= H;
            prev_v_r <= V;
        end
    end

    assign h_rise = !prev_h_r &  H;
    assign h_fall =  prev_h_r & !H;
    assign v_rise = !prev_v_r &  V;
    assign v_fall =  prev_v_r & !V;

endmodule

// File: rtl/sequence_extractor.sv
// Recovers the generator seed from the first active line after vertical blanking,
// blanks that line in the outgoing stream and masks it from the line de-rotator.
module sequence_extractor
    import video_scrambler_pkg::*;
#(
    parameter int ACTIVE_WORDS = ACTIVE_VIDEO_WORDS,
    parameter int SEED_WORDS   = 8,
    parameter int TAIL_CYCLES  = 4
) (
    input logic                 clk,
    input logic                 reset,
    sequence_extractor_if.slave bus
);

    localparam int CNT_W  = $clog2(ACTIVE_WORDS + 1);
    localparam int TCNT_W = $clog2(TAIL_CYCLES + 1);

    extractor_state_e          state_r, state_nx_s;
    logic [CNT_W-1:0]          cnt_r, cnt_nx_s, idx_s;
    logic [TCNT_W-1:0]         tcnt_r, tcnt_nx_s;
    logic                      mask_r, mask_nx_s;
    logic [9:0]                seed_r [SEED_WORDS];
    logic [10*SEED_WORDS-1:0]  seed_data_s;
    logic                      seed_load_r, seed_err_r, load_nx_s, err_nx_s;
    logic                      capture_word_s, wr_en_s;
    logic                      h_rise_s, h_fall_s, v_rise_s, v_fall_s;

    bt656_edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .H      (bus.H),
        .V      (bus.V),
        .h_rise (h_rise_s),
        .h_fall (h_fall_s),
        .v_rise (v_rise_s),
        .v_fall (v_fall_s)
    );

    // Word 0 arrives in ARMED on the H fall itself, so it is taken before CAPTURE is entered.
    assign idx_s          = (state_r == EXT_CAPTURE) ? cnt_r : {CNT_W{1'b0}};
    assign capture_word_s = ((state_r == EXT_ARMED) && h_fall_s && !bus.V) ||
                            ((state_r == EXT_CAPTURE) && !bus.H && !bus.V);
    assign wr_en_s        = capture_word_s && (idx_s < CNT_W'(SEED_WORDS));

    // Next-state, counter and strobe logic
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        tcnt_nx_s  = tcnt_r;
        mask_nx_s  = mask_r;
        err_nx_s   = 1'b0;
        load_nx_s  = wr_en_s && (idx_s == CNT_W'(SEED_WORDS - 1));
        case (state_r)
            EXT_IDLE: begin
                if (bus.V) begin
                    state_nx_s = EXT_VBLANK;
                    mask_nx_s  = 1'b1;
                end else begin
                    state_nx_s = EXT_IDLE;
                end
            end
            EXT_VBLANK: begin
                if (v_fall_s) begin
                    state_nx_s = EXT_ARMED;
                end else begin
                    state_nx_s = EXT_VBLANK;
                end
            end
            EXT_ARMED: begin
                if (bus.V) begin
                    state_nx_s = EXT_VBLANK;
                end else if (h_fall_s) begin
                    state_nx_s = (ACTIVE_WORDS == 1) ? EXT_TAIL : EXT_CAPTURE;
                    cnt_nx_s   = CNT_W'(1);
                    tcnt_nx_s  = {TCNT_W{1'b0}};
                end else begin
                    state_nx_s = EXT_ARMED;
                end
            end
            EXT_CAPTURE: begin
                if (h_rise_s || v_rise_s) begin
                    err_nx_s = 1'b1;
                    if (bus.V) begin
                        state_nx_s = EXT_VBLANK;
                        mask_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = EXT_DONE;
                        mask_nx_s  = 1'b0;
                    end
                end else if (cnt_r == CNT_W'(ACTIVE_WORDS - 1)) begin
                    state_nx_s = EXT_TAIL;
                    tcnt_nx_s  = {TCNT_W{1'b0}};
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            EXT_TAIL: begin
                if (tcnt_r == TCNT_W'(TAIL_CYCLES - 1)) begin
                    state_nx_s = EXT_DONE;
                    mask_nx_s  = 1'b0;
                end else begin
                    tcnt_nx_s = tcnt_r + TCNT_W'(1);
                end
            end
            EXT_DONE: begin
                if (bus.V) begin
                    state_nx_s = EXT_VBLANK;
                    mask_nx_s  = 1'b1;
                end else begin
                    state_nx_s = EXT_DONE;
                end
            end
            default: begin
                state_nx_s = EXT_IDLE;
                mask_nx_s  = 1'b0;
            end
        endcase
    end

    // FSM state, counters, mask and output strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= EXT_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            tcnt_r      <= {TCNT_W{1'b0}};
            mask_r      <= 1'b0;
            seed_load_r <= 1'b0;
            seed_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cnt_r       <= cnt_nx_s;
            tcnt_r      <= tcnt_nx_s;
            mask_r      <= mask_nx_s;
            seed_load_r <= load_nx_s;
            seed_err_r  <= err_nx_s;
        end
    end

    // Seed slices; a partial capture overwrites only the slices it received
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SEED_WORDS; i++) begin
                seed_r[i] <= 10'h000;
            end
        end else begin
            for (int i = 0; i < SEED_WORDS; i++) begin
                if (wr_en_s && (idx_s == CNT_W'(i))) begin
                    seed_r[i] <= bus.bt656_stream_in;
                end
            end
        end
    end

    // Pack seed slices, word 0 in the low bits
    always_comb begin
        seed_data_s = {(10*SEED_WORDS){1'b0}};
        for (int i = 0; i < SEED_WORDS; i++) begin
            seed_data_s[10*i +: 10] = seed_r[i];
        end
    end

    assign bus.seed_data        = seed_data_s;
    assign bus.seed_load        = seed_load_r;
    assign bus.seed_err         = seed_err_r;
    assign bus.V_out            = bus.V | mask_r;
    assign bus.bt656_stream_out = capture_word_s ? black_word(idx_s[0]) : bus.bt656_stream_in;

endmodule

// File: tb/tb_sequence_extractor.sv
// Self-checking bench for sequence_extractor: random frames against a word-level reference model.
module tb_sequence_extractor;

    localparam int AW = 1440;
    localparam int SW = 8;
    localparam int TC = 4;
    localparam int HB = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequence_extractor_if #(.SEED_WORDS(SW)) bus ();

    sequence_extractor #(
        .ACTIVE_WORDS (AW),
        .SEED_WORDS   (SW),
        .TAIL_CYCLES  (TC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         checks = 0;
    int         failures = 0;
    int         load_cnt, err_cnt, load_at;
    logic [9:0] line_data [AW];
    logic [9:0] obs_out   [AW];
    logic       obs_vout  [AW];
    logic       obs_hv    [HB];
    logic [9:0] exp_seed  [SW];

    function automatic logic [10*SW-1:0] pack_seed();
        logic [10*SW-1:0] p;
        for (int i = 0; i < SW; i++) p[10*i +: 10] = exp_seed[i];
        return p;
    endfunction

    // Reference: the first blank_upto words of a key line become black, the rest pass through.
    function automatic logic [9:0] exp_word(input int i, input int blank_upto);
        if (i < blank_upto) return (i % 2 == 0) ? 10'h200 : 10'h040;
        return line_data[i];
    endfunction

    task automatic model_capture(input int n);
        for (int i = 0; i < SW && i < n; i++) exp_seed[i] = line_data[i];
    endtask

    task automatic drive_word(input logic h, input logic v, input logic [9:0] d, input logic r);
        @(posedge clk);
        #1;
        reset = r;
        bus.H = h;
        bus.V = v;
        bus.bt656_stream_in = d;
        #1;
        if (bus.seed_load === 1'b1) load_cnt++;
        if (bus.seed_err === 1'b1) err_cnt++;
    endtask

    task automatic hblank(input logic v);
        for (int j = 0; j < HB; j++) begin
            drive_word(1'b1, v, 10'($urandom), 1'b0);
            obs_hv[j] = bus.V_out;
        end
    endtask

    task automatic active(input int n, input logic v, input int rst_at);
        logic r;
        for (int i = 0; i < n; i++) begin
            r = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 3);
            drive_word(1'b0, v, line_data[i], r);
            obs_out[i]  = bus.bt656_stream_out;
            obs_vout[i] = bus.V_out;
            if (bus.seed_load === 1'b1 && load_at < 0) load_at = i;
        end
    endtask

    task automatic fill_line(input bit seq_seed);
        for (int i = 0; i < AW; i++)
            line_data[i] = (seq_seed && i < SW) ? 10'(i + 1) : 10'($urandom);
    endtask

    task automatic vblank(input int nlines);
        for (int l = 0; l < nlines; l++) begin
            hblank(1'b1);
            fill_line(1'b0);
            active(HB, 1'b1, -1);
        end
    endtask

    task automatic clear_obs();
        load_cnt = 0;
        err_cnt  = 0;
        load_at  = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.H = 1'b1;
        bus.V = 1'b1;
        bus.bt656_stream_in = 10'h155;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (bus.seed_data !== '0) begin failures++; $display("FAIL rst_seed_data: got %h want 0", bus.seed_data); end
        checks++; if (bus.seed_load !== 1'b0) begin failures++; $display("FAIL rst_seed_load: got %b want 0", bus.seed_load); end
        checks++; if (bus.seed_err !== 1'b0) begin failures++; $display("FAIL rst_seed_err: got %b want 0", bus.seed_err); end
        checks++; if (bus.V_out !== 1'b1) begin failures++; $display("FAIL rst_vout_v1: got %b want 1", bus.V_out); end
        checks++; if (bus.bt656_stream_out !== 10'h155) begin failures++; $display("FAIL rst_bypass: got %h want 155", bus.bt656_stream_out); end
        bus.V = 1'b0;
        bus.H = 1'b0;
        bus.bt656_stream_in = 10'h3A5;
        #1;
        checks++; if (bus.V_out !== 1'b0) begin failures++; $display("FAIL rst_vout_v0: got %b want 0", bus.V_out); end
        checks++; if (bus.bt656_stream_out !== 10'h3A5) begin failures++; $display("FAIL rst_bypass2: got %h want 3a5", bus.bt656_stream_out); end
        for (int i = 0; i < SW; i++) exp_seed[i] = 10'h000;
        drive_word(1'b1, 1'b1, 10'h000, 1'b0);
    endtask

    // Full key frame: nvb blanking lines, V falls in the H interval, then the key line and its tail.
    task automatic test_key_frame(input int nvb, input bit seq_seed);
        int bad, vbad, tbad;
        clear_obs();
        vblank(nvb);
        hblank(1'b0);
        fill_line(seq_seed);
        active(AW, 1'b0, -1);
        model_capture(AW);
        hblank(1'b0);
        bad = 0; vbad = 0; tbad = 0;
        for (int i = 0; i < AW; i++) begin
            if (obs_out[i] !== exp_word(i, AW)) bad++;
            if (obs_vout[i] !== 1'b1) vbad++;
        end
        for (int j = 0; j < HB; j++) if (obs_hv[j] !== (j < TC)) tbad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL key_blank: got %0d bad words want 0", bad); end
        checks++; if (vbad !== 0) begin failures++; $display("FAIL key_vout: got %0d low words want 0", vbad); end
        checks++; if (tbad !== 0) begin failures++; $display("FAIL key_tail_vout: got %0d bad tail words want 0", tbad); end
        checks++; if (load_cnt !== 1) begin failures++; $display("FAIL key_load_cnt: got %0d want 1", load_cnt); end
        checks++; if (load_at !== SW) begin failures++; $display("FAIL key_load_at: got %0d want %0d", load_at, SW); end
        checks++; if (err_cnt !== 0) begin failures++; $display("FAIL key_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (bus.seed_data !== pack_seed()) begin failures++; $display("FAIL key_seed: got %h want %h", bus.seed_data, pack_seed()); end
    endtask

    task automatic test_nominal();
        test_key_frame(20, 1'b1);
        checks++; if (bus.seed_data[9:0] !== 10'h001) begin failures++; $display("FAIL nom_seed_w0: got %h want 001", bus.seed_data[9:0]); end
        checks++; if (bus.seed_data[79:70] !== 10'h008) begin failures++; $display("FAIL nom_seed_w7: got %h want 008", bus.seed_data[79:70]); end
    endtask

    task automatic test_second_line();
        int bad, vbad;
        clear_obs();
        fill_line(1'b0);
        active(AW, 1'b0, -1);
        hblank(1'b0);
        bad = 0; vbad = 0;
        for (int i = 0; i < AW; i++) begin
            if (obs_out[i] !== exp_word(i, 0)) bad++;
            if (obs_vout[i] !== 1'b0) vbad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL second_pass: got %0d bad words want 0", bad); end
        checks++; if (vbad !== 0) begin failures++; $display("FAIL second_vout: got %0d high words want 0", vbad); end
        checks++; if (load_cnt !== 0) begin failures++; $display("FAIL second_load: got %0d want 0", load_cnt); end
    endtask

    task automatic test_short_line();
        int bad;
        logic [9:0] old5;
        old5 = exp_seed[5];
        clear_obs();
        vblank(3);
        hblank(1'b0);
        fill_line(1'b0);
        active(5, 1'b0, -1);
        model_capture(5);
        hblank(1'b0);
        bad = 0;
        for (int i = 0; i < 5; i++) if (obs_out[i] !== exp_word(i, 5)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL short_blank: got %0d bad words want 0", bad); end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL short_err: got %0d want 1", err_cnt); end
        checks++; if (load_cnt !== 0) begin failures++; $display("FAIL short_load: got %0d want 0", load_cnt); end
        checks++; if (bus.seed_data !== pack_seed()) begin failures++; $display("FAIL short_seed: got %h want %h", bus.seed_data, pack_seed()); end
        checks++; if (bus.seed_data[59:50] !== old5) begin failures++; $display("FAIL short_keep5: got %h want %h", bus.seed_data[59:50], old5); end
        checks++; if (obs_hv[HB-1] !== 1'b0) begin failures++; $display("FAIL short_vout: got %b want 0", obs_hv[HB-1]); end
    endtask

    task automatic test_v_abort();
        int bad;
        clear_obs();
        vblank(3);
        hblank(1'b0);
        fill_line(1'b0);
        active(700, 1'b0, -1);
        model_capture(700);
        bad = 0;
        for (int i = 0; i < 700; i++) if (obs_out[i] !== exp_word(i, 700)) bad++;
        fill_line(1'b0);
        active(HB, 1'b1, -1);
        for (int i = 0; i < HB; i++) if (obs_out[i] !== exp_word(i, 0)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL vabort_words: got %0d bad words want 0", bad); end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL vabort_err: got %0d want 1", err_cnt); end
        checks++; if (load_cnt !== 1) begin failures++; $display("FAIL vabort_load: got %0d want 1", load_cnt); end
        checks++; if (bus.seed_data !== pack_seed()) begin failures++; $display("FAIL vabort_seed: got %h want %h", bus.seed_data, pack_seed()); end
        test_key_frame(3, 1'b0);
    endtask

    task automatic test_reset_mid_capture();
        int bad, vbad;
        clear_obs();
        vblank(3);
        hblank(1'b0);
        fill_line(1'b0);
        active(AW, 1'b0, 300);
        hblank(1'b0);
        for (int i = 0; i < SW; i++) exp_seed[i] = 10'h000;
        bad = 0; vbad = 0;
        for (int i = 0; i < AW; i++) begin
            if (obs_out[i] !== exp_word(i, 300)) bad++;
            if (obs_vout[i] !== (i < 300)) vbad++;
        end
        checks++; if (obs_out[300] !== line_data[300]) begin failures++; $display("FAIL rstmid_bypass: got %h want %h", obs_out[300], line_data[300]); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rstmid_words: got %0d bad words want 0", bad); end
        checks++; if (vbad !== 0) begin failures++; $display("FAIL rstmid_vout: got %0d bad words want 0", vbad); end
        checks++; if (load_cnt !== 1) begin failures++; $display("FAIL rstmid_load: got %0d want 1", load_cnt); end
        checks++; if (bus.seed_data !== pack_seed()) begin failures++; $display("FAIL rstmid_seed: got %h want %h", bus.seed_data, pack_seed()); end
        test_key_frame(3, 1'b0);
    endtask

    task automatic test_simultaneous();
        int bad;
        clear_obs();
        vblank(3);
        hblank(1'b1);
        fill_line(1'b0);
        active(AW, 1'b0, -1);
        bad = 0;
        for (int i = 0; i < AW; i++) if (obs_out[i] !== exp_word(i, 0)) bad++;
        checks++; if (bad !== 0) begin failures++; $display("FAIL simul_pass: got %0d bad words want 0", bad); end
        checks++; if (load_cnt !== 0) begin failures++; $display("FAIL simul_load: got %0d want 0", load_cnt); end
        test_key_frame(0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_second_line();
        test_short_line();
        test_v_abort();
        test_reset_mid_capture();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
